// File: rtl/p4_router_egress_demux.sv
// Egress demultiplexer: steers each packet from the P4 pipeline to one egress
// stream chosen by per-packet metadata queued in a small FIFO; unmapped packets are dropped.
module p4_router_egress_demux #(
  parameter int DATA_BYTES        = 8,
  parameter int NUM_EGR_PORTS     = 11,
  parameter int EGR_SPEC_ID_WIDTH = 8,
  parameter int ING_PORT_ID_WIDTH = 8,
  parameter int META_FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic [DATA_BYTES*8-1:0]      s_tdata,
  input  logic [DATA_BYTES-1:0]        s_tkeep,
  input  logic                         s_tlast,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [EGR_SPEC_ID_WIDTH-1:0] meta_egr_spec,
  input  logic [ING_PORT_ID_WIDTH-1:0] meta_ing_port,
  input  logic                         meta_valid,
  output logic [DATA_BYTES*8-1:0]      m_tdata,
  output logic [DATA_BYTES-1:0]        m_tkeep,
  output logic                         m_tlast,
  output logic [NUM_EGR_PORTS-1:0]     m_tvalid,
  input  logic [NUM_EGR_PORTS-1:0]     m_tready,
  output logic [ING_PORT_ID_WIDTH-1:0] m_ing_port,
  output logic [31:0]                  drop_count,
  output logic                         meta_overflow
);
  localparam int AW = $clog2(META_FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;
  state_t r_state, w_state_next;

  logic [EGR_SPEC_ID_WIDTH-1:0] r_fifo_egr [META_FIFO_DEPTH];
  logic [ING_PORT_ID_WIDTH-1:0] r_fifo_ing [META_FIFO_DEPTH];
  logic [AW-1:0]                r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]                r_count;
  logic [EGR_SPEC_ID_WIDTH-1:0] r_cur_egr;
  logic [ING_PORT_ID_WIDTH-1:0] r_cur_ing;
  logic [31:0]                  r_drop_count;

  logic                     w_full, w_pop, w_push, w_head_mapped;
  logic                     w_fwd_ready, w_drop_done;
  logic [NUM_EGR_PORTS-1:0] w_sel;

  // A full FIFO still accepts a push when the FSM pops in the same cycle.
  assign w_full        = (r_count == CW'(META_FIFO_DEPTH));
  assign w_pop         = !srst && (r_state == ST_IDLE) && (r_count != '0);
  assign w_push        = !srst && meta_valid && (!w_full || w_pop);
  assign meta_overflow = !srst && meta_valid && w_full && !w_pop;
  assign w_head_mapped = (32'(r_fifo_egr[r_rd_ptr]) < NUM_EGR_PORTS);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_egr[r_wr_ptr] <= meta_egr_spec;
      r_fifo_ing[r_wr_ptr] <= meta_ing_port;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  for (genvar gi = 0; gi < NUM_EGR_PORTS; gi++) begin : g_sel
    assign w_sel[gi] = (r_cur_egr == EGR_SPEC_ID_WIDTH'(gi));
  end

  assign w_fwd_ready = |(w_sel & m_tready);
  assign w_drop_done = !srst && (r_state == ST_DROP) && s_tvalid && s_tlast;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    s_tready     = 1'b0;
    m_tvalid     = '0;
    m_ing_port   = '0;
    if (!srst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) w_state_next = w_head_mapped ? ST_FWD : ST_DROP;
        end
        ST_FWD: begin
          m_tvalid   = w_sel & {NUM_EGR_PORTS{s_tvalid}};
          s_tready   = w_fwd_ready;
          m_ing_port = r_cur_ing;
          if (s_tvalid && w_fwd_ready && s_tlast) w_state_next = ST_IDLE;
        end
        ST_DROP: begin
          s_tready = 1'b1;
          if (s_tvalid && s_tlast) w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_cur_egr    <= '0;
      r_cur_ing    <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_pop) begin
        r_cur_egr <= r_fifo_egr[r_rd_ptr];
        r_cur_ing <= r_fifo_ing[r_rd_ptr];
      end
      if (w_drop_done && (r_drop_count != 32'hFFFF_FFFF)) begin
        r_drop_count <= r_drop_count + 32'd1;
      end
    end
  end

  assign m_tdata    = s_tdata;
  assign m_tkeep    = s_tkeep;
  assign m_tlast    = s_tlast;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_p4_router_egress_demux.sv
// Self-checking bench for p4_router_egress_demux: directed scenarios plus
// randomized packets checked against a queue-based routing model.
module tb_p4_router_egress_demux;
  localparam int DB    = 8;
  localparam int NP    = 11;
  localparam int EW    = 8;
  localparam int IW    = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            srst;
  logic [DB*8-1:0] s_tdata;
  logic [DB-1:0]   s_tkeep;
  logic            s_tlast;
  logic            s_tvalid;
  logic            s_tready;
  logic [EW-1:0]   meta_egr_spec;
  logic [IW-1:0]   meta_ing_port;
  logic            meta_valid;
  logic [DB*8-1:0] m_tdata;
  logic [DB-1:0]   m_tkeep;
  logic            m_tlast;
  logic [NP-1:0]   m_tvalid;
  logic [NP-1:0]   m_tready;
  logic [IW-1:0]   m_ing_port;
  logic [31:0]     drop_count;
  logic            meta_overflow;

  int checks   = 0;
  int failures = 0;
  int exp_drop = 0;

  p4_router_egress_demux #(
    .DATA_BYTES(DB), .NUM_EGR_PORTS(NP), .EGR_SPEC_ID_WIDTH(EW),
    .ING_PORT_ID_WIDTH(IW), .META_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .srst(srst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .meta_egr_spec(meta_egr_spec), .meta_ing_port(meta_ing_port), .meta_valid(meta_valid),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_ing_port(m_ing_port), .drop_count(drop_count), .meta_overflow(meta_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
    meta_valid = 1'b0; meta_egr_spec = '0; meta_ing_port = '0;
  endtask

  task automatic drive_beat(input logic [DB*8-1:0] d, input logic [DB-1:0] k, input logic l);
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
  endtask

  task automatic push_meta(input logic [EW-1:0] egr, input logic [IW-1:0] ing);
    meta_valid = 1'b1; meta_egr_spec = egr; meta_ing_port = ing;
    tick();
    meta_valid = 1'b0;
  endtask

  // Leaves the caller at the negedge where s_tready was seen high.
  task automatic wait_accept(output bit ok, output int stalls);
    ok = 1'b0;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    srst = 1'b1; idle_inputs(); m_tready = '1;
    s_tvalid = 1'b1; s_tlast = 1'b1; meta_valid = 1'b1; meta_egr_spec = 8'd2;
    tick();
    @(negedge clk);
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_s_tready: got %b expected 0", s_tready); end
    checks++; if (m_tvalid !== '0) begin failures++; $display("FAIL reset_m_tvalid: got %h expected 0", m_tvalid); end
    checks++; if (m_ing_port !== '0) begin failures++; $display("FAIL reset_m_ing_port: got %h expected 0", m_ing_port); end
    checks++; if (drop_count !== 32'd0) begin failures++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
    checks++; if (meta_overflow !== 1'b0) begin failures++; $display("FAIL reset_meta_overflow: got %b expected 0", meta_overflow); end
    tick();
    srst = 1'b0; meta_valid = 1'b0; exp_drop = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b0 || m_tvalid !== '0) begin
        failures++; $display("FAIL reset_fifo_empty: got s_tready=%b m_tvalid=%h expected 0/0", s_tready, m_tvalid);
      end
      tick();
    end
    idle_inputs();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [DB*8-1:0] d;
    logic [NP-1:0]   exp_v;
    bit ok; int st;
    m_tready = '1; exp_v = NP'(1) << 3;
    push_meta(8'd3, 8'd5);
    for (int b = 0; b < 4; b++) begin
      d = {$urandom, $urandom};
      drive_beat(d, 8'hFF, b == 3);
      wait_accept(ok, st);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL basic_timeout: beat %0d got no s_tready expected handshake", b);
      end else begin
        checks++; if (m_tvalid !== exp_v) begin failures++; $display("FAIL basic_tvalid: got %h expected %h", m_tvalid, exp_v); end
        checks++; if (m_ing_port !== 8'd5) begin failures++; $display("FAIL basic_ing: got %0d expected 5", m_ing_port); end
        checks++; if (m_tdata !== d || m_tlast !== (b == 3)) begin
          failures++; $display("FAIL basic_data: got %h/%b expected %h/%b", m_tdata, m_tlast, d, b == 3);
        end
        tick();
      end
    end
    s_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b0 || m_tvalid !== '0 || m_ing_port !== '0) begin
      failures++; $display("FAIL basic_idle: got s_tready=%b m_tvalid=%h ing=%0d expected 0/0/0", s_tready, m_tvalid, m_ing_port);
    end
    tick();
    idle_inputs();
    $display("test_basic pkt egr=3 ing=5 beats=4");
  endtask

  task automatic test_drop();
    bit ok; int st;
    m_tready = '1;
    push_meta(8'hFF, 8'd7);
    for (int b = 0; b < 3; b++) begin
      drive_beat({$urandom, $urandom}, 8'hFF, b == 2);
      wait_accept(ok, st);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL drop_timeout: beat %0d got no s_tready expected handshake", b);
      end else begin
        checks++; if (m_tvalid !== '0) begin failures++; $display("FAIL drop_tvalid: got %h expected 0", m_tvalid); end
        if (b > 0) begin
          checks++; if (st !== 0) begin failures++; $display("FAIL drop_ready_gap: got %0d stall cycles expected 0", st); end
        end
        if (b == 2) begin
          checks++; if (drop_count !== 32'(exp_drop)) begin failures++; $display("FAIL drop_count_before: got %0d expected %0d", drop_count, exp_drop); end
        end
        tick();
      end
    end
    exp_drop++;
    s_tvalid = 1'b0;
    @(negedge clk);
    checks++; if (drop_count !== 32'(exp_drop)) begin failures++; $display("FAIL drop_count_after: got %0d expected %0d", drop_count, exp_drop); end
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL drop_idle: got s_tready=%b expected 0", s_tready); end
    tick();
    idle_inputs();
    $display("test_drop pkt egr=0xFF beats=3 drop_count=%0d", exp_drop);
  endtask

  task automatic test_overflow();
    int eg [5] = '{4, 6, 0, 9, 2};
    bit ok; int st;
    m_tready = '0;
    push_meta(8'd1, 8'd10);
    drive_beat(64'hA5A5_0000_0000_0001, 8'hFF, 1'b1);
    tick();
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b0 || m_tvalid !== NP'(2)) begin
      failures++; $display("FAIL ovf_stall: got s_tready=%b m_tvalid=%h expected 0/002", s_tready, m_tvalid);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      meta_valid = 1'b1; meta_egr_spec = 8'(eg[i]); meta_ing_port = 8'(20 + i);
      @(negedge clk);
      checks++;
      if (meta_overflow !== (i == 4)) begin
        failures++; $display("FAIL ovf_pulse: push %0d got %b expected %b", i, meta_overflow, i == 4);
      end
      tick();
    end
    meta_valid = 1'b0;
    @(negedge clk);
    checks++; if (meta_overflow !== 1'b0) begin failures++; $display("FAIL ovf_pulse_end: got %b expected 0", meta_overflow); end
    tick();
    m_tready = '1;
    wait_accept(ok, st);
    checks++;
    if (!ok || m_tvalid !== NP'(2) || m_ing_port !== 8'd10) begin
      failures++; $display("FAIL ovf_release: got ok=%b m_tvalid=%h ing=%0d expected 1/002/10", ok, m_tvalid, m_ing_port);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_beat({$urandom, $urandom}, 8'hFF, 1'b1);
      wait_accept(ok, st);
      checks++;
      if (!ok || m_tvalid !== (NP'(1) << eg[i]) || m_ing_port !== 8'(20 + i)) begin
        failures++; $display("FAIL ovf_order: pkt %0d got ok=%b m_tvalid=%h ing=%0d expected egr %0d ing %0d", i, ok, m_tvalid, m_ing_port, eg[i], 20 + i);
      end
      tick();
    end
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL ovf_lost_entry: got s_tready=%b expected 0", s_tready); end
      tick();
    end
    idle_inputs();
    $display("test_overflow 5 pushes, 4 packets routed");
  endtask

  task automatic test_backpressure();
    logic [5:0]      pat;
    logic [DB*8-1:0] bt [4];
    int b;
    pat = 6'b111001;
    for (int i = 0; i < 4; i++) bt[i] = {$urandom, $urandom};
    m_tready = '1;
    push_meta(8'd2, 8'd3);
    tick();
    b = 0;
    for (int c = 0; c < 6; c++) begin
      m_tready = {NP{~pat[c]}};
      m_tready[2] = pat[c];
      drive_beat(bt[b], 8'hFF, b == 3);
      @(negedge clk);
      checks++; if (s_tready !== pat[c]) begin failures++; $display("FAIL bp_ready: cycle %0d got %b expected %b", c, s_tready, pat[c]); end
      checks++; if (m_tvalid !== NP'(4)) begin failures++; $display("FAIL bp_tvalid: cycle %0d got %h expected 004", c, m_tvalid); end
      checks++; if (m_tdata !== bt[b]) begin failures++; $display("FAIL bp_data: cycle %0d got %h expected %h", c, m_tdata, bt[b]); end
      if (pat[c]) b++;
      tick();
    end
    checks++; if (b !== 4) begin failures++; $display("FAIL bp_beats: got %0d expected 4", b); end
    s_tvalid = 1'b0; m_tready = '1;
    @(negedge clk);
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL bp_idle: got s_tready=%b expected 0", s_tready); end
    tick();
    idle_inputs();
    $display("test_backpressure pkt egr=2 beats=%0d", b);
  endtask

  task automatic test_full_push_pop();
    int exp_egr [5] = '{5, 10, 3, 7, 8};
    int exp_ing [5] = '{50, 51, 52, 53, 60};
    bit ok; int st;
    m_tready = '0;
    push_meta(8'd0, 8'd40);
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      meta_valid = 1'b1; meta_egr_spec = 8'(exp_egr[i]); meta_ing_port = 8'(exp_ing[i]);
      @(negedge clk);
      checks++; if (meta_overflow !== 1'b0) begin failures++; $display("FAIL full_fill_ovf: push %0d got %b expected 0", i, meta_overflow); end
      tick();
    end
    meta_valid = 1'b0; m_tready = '1;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== NP'(1)) begin
      failures++; $display("FAIL full_release: got s_tready=%b m_tvalid=%h expected 1/001", s_tready, m_tvalid);
    end
    tick();
    s_tvalid = 1'b0;
    meta_valid = 1'b1; meta_egr_spec = 8'd8; meta_ing_port = 8'd60;
    @(negedge clk);
    checks++; if (meta_overflow !== 1'b0) begin failures++; $display("FAIL full_pushpop_ovf: got %b expected 0", meta_overflow); end
    tick();
    meta_egr_spec = 8'd1; meta_ing_port = 8'd61;
    @(negedge clk);
    checks++; if (meta_overflow !== 1'b1) begin failures++; $display("FAIL full_still_full: got %b expected 1", meta_overflow); end
    tick();
    meta_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_beat({$urandom, $urandom}, 8'hFF, 1'b1);
      wait_accept(ok, st);
      checks++;
      if (!ok || m_tvalid !== (NP'(1) << exp_egr[i]) || m_ing_port !== 8'(exp_ing[i])) begin
        failures++; $display("FAIL full_order: pkt %0d got ok=%b m_tvalid=%h ing=%0d expected egr %0d ing %0d", i, ok, m_tvalid, m_ing_port, exp_egr[i], exp_ing[i]);
      end
      tick();
    end
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL full_extra_entry: got s_tready=%b expected 0", s_tready); end
      tick();
    end
    idle_inputs();
    $display("test_full_push_pop 5 packets routed");
  endtask

  task automatic test_reset_mid();
    logic [DB*8-1:0] d;
    bit ok; int st;
    m_tready = '1;
    push_meta(8'd5, 8'd9);
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    wait_accept(ok, st);
    checks++;
    if (!ok || m_tvalid !== (NP'(1) << 5)) begin
      failures++; $display("FAIL rstmid_first: got ok=%b m_tvalid=%h expected 1/020", ok, m_tvalid);
    end
    tick();
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    m_tready = '0; meta_valid = 1'b1; meta_egr_spec = 8'd4; meta_ing_port = 8'd1;
    tick();
    meta_valid = 1'b0; srst = 1'b1; m_tready = '1;
    @(negedge clk);
    checks++;
    if (m_tvalid !== '0 || s_tready !== 1'b0 || meta_overflow !== 1'b0) begin
      failures++; $display("FAIL rstmid_during: got m_tvalid=%h s_tready=%b ovf=%b expected 0/0/0", m_tvalid, s_tready, meta_overflow);
    end
    tick();
    srst = 1'b0; exp_drop = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m_tvalid !== '0 || s_tready !== 1'b0 || m_ing_port !== '0 || drop_count !== 32'(exp_drop)) begin
        failures++; $display("FAIL rstmid_after: cycle %0d got m_tvalid=%h s_tready=%b ing=%0d drop=%0d expected 0/0/0/0", i, m_tvalid, s_tready, m_ing_port, drop_count);
      end
      tick();
    end
    s_tvalid = 1'b0;
    push_meta(8'd7, 8'd2);
    d = {$urandom, $urandom};
    drive_beat(d, 8'h0F, 1'b1);
    wait_accept(ok, st);
    checks++;
    if (!ok || m_tvalid !== (NP'(1) << 7) || m_ing_port !== 8'd2 || m_tdata !== d || m_tkeep !== 8'h0F) begin
      failures++; $display("FAIL rstmid_next: got ok=%b m_tvalid=%h ing=%0d data=%h expected 1/080/2/%h", ok, m_tvalid, m_ing_port, m_tdata, d);
    end
    tick();
    idle_inputs();
    $display("test_reset_mid recovered, pkt egr=7 ing=2");
  endtask

  task automatic test_random();
    logic [EW-1:0]   q_egr [$];
    logic [IW-1:0]   q_ing [$];
    logic [EW-1:0]   egr;
    logic [IW-1:0]   ing;
    logic [DB*8-1:0] d;
    logic [DB-1:0]   kp;
    logic [NP-1:0]   exp_v;
    bit mapped, acc;
    int k, len;
    for (int r = 0; r < 25; r++) begin
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) begin
        egr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(NP, 255)) : 8'($urandom_range(0, NP - 1));
        ing = 8'($urandom);
        q_egr.push_back(egr);
        q_ing.push_back(ing);
        meta_valid = 1'b1; meta_egr_spec = egr; meta_ing_port = ing;
        @(negedge clk);
        checks++; if (meta_overflow !== 1'b0) begin failures++; $display("FAIL rnd_ovf: got %b expected 0", meta_overflow); end
        tick();
      end
      meta_valid = 1'b0;
      for (int p = 0; p < k; p++) begin
        egr = q_egr.pop_front();
        ing = q_ing.pop_front();
        mapped = (int'(egr) < NP);
        exp_v = mapped ? (NP'(1) << egr) : '0;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          if ($urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0; m_tready = NP'($urandom);
            @(negedge clk);
            checks++; if (m_tvalid !== '0) begin failures++; $display("FAIL rnd_gap_tvalid: got %h expected 0", m_tvalid); end
            tick();
          end
          d = {$urandom, $urandom};
          kp = 8'($urandom);
          drive_beat(d, kp, b == len - 1);
          acc = 1'b0;
          for (int cyc = 0; cyc < 60; cyc++) begin
            m_tready = NP'($urandom);
            @(negedge clk);
            if (s_tready) begin
              acc = 1'b1;
              checks++; if (m_tvalid !== exp_v) begin failures++; $display("FAIL rnd_tvalid: got %h expected %h", m_tvalid, exp_v); end
              if (mapped) begin
                checks++;
                if (m_ing_port !== ing || m_tdata !== d || m_tkeep !== kp || m_tlast !== (b == len - 1)) begin
                  failures++; $display("FAIL rnd_beat: got ing=%0d data=%h keep=%h last=%b expected %0d/%h/%h/%b", m_ing_port, m_tdata, m_tkeep, m_tlast, ing, d, kp, b == len - 1);
                end
              end
              break;
            end
            checks++;
            if (m_tvalid !== '0 && !(mapped && m_tvalid === exp_v && m_tready[egr[3:0]] === 1'b0)) begin
              failures++; $display("FAIL rnd_stall: got m_tvalid=%h m_tready=%h expected stall on %h", m_tvalid, m_tready, exp_v);
            end
            @(posedge clk);
            #1;
          end
          checks++;
          if (!acc) begin
            failures++; $display("FAIL rnd_timeout: got no handshake expected beat %0d accepted", b);
          end else begin
            if (!mapped && b == len - 1) exp_drop++;
            tick();
          end
        end
        s_tvalid = 1'b0; m_tready = '1;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== '0 || m_ing_port !== '0 || drop_count !== 32'(exp_drop)) begin
          failures++; $display("FAIL rnd_after_pkt: got s_tready=%b m_tvalid=%h ing=%0d drop=%0d expected 0/0/0/%0d", s_tready, m_tvalid, m_ing_port, drop_count, exp_drop);
        end
        tick();
        $display("rnd pkt egr=%0d ing=%0d beats=%0d %s", egr, ing, len, mapped ? "fwd" : "drop");
      end
    end
    idle_inputs();
  endtask

  initial begin
    srst = 1'b1;
    idle_inputs();
    m_tready = '1;
    test_reset();
    test_basic();
    test_drop();
    test_overflow();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
